// File: rtl/steer_en_gen.sv
// steer_en_gen: rider-presence / steering-enable detector.
// Block-averages qualified left/right load-cell samples, derives weight and
// balance flags from the averages, and runs an IDLE/WAIT/STEER machine that
// enables steering once the rider has stood balanced for a full timer period.
module steer_en_gen #(
  parameter int LD_W         = 12,
  parameter int MIN_RIDER_WT = 'h200,
  parameter int WT_HYST      = 'h40,
  parameter int BAL_SHIFT    = 2,
  parameter int OFF_SHIFT    = 4,
  parameter int AVG_LOG2     = 2,
  parameter int TMR_W        = 26
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ld_vld,
  input  logic [LD_W-1:0] i_lft_ld,
  input  logic [LD_W-1:0] i_rght_ld,
  output logic            o_en_steer,
  output logic            o_rider_off,
  output logic            o_avg_vld
);

  localparam int ACC_W = LD_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NSMP  = 1 << AVG_LOG2;

  // Hysteresis thresholds on the L+R sum (LD_W+1 bits so the sum cannot wrap).
  localparam int SUM_LO_I = MIN_RIDER_WT - WT_HYST;
  localparam int SUM_HI_I = MIN_RIDER_WT + WT_HYST;
  localparam logic [LD_W:0] SUM_LO = SUM_LO_I[LD_W:0];
  localparam logic [LD_W:0] SUM_HI = SUM_HI_I[LD_W:0];

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] STEER = 2'd2;

  logic [ACC_W-1:0] r_acc_l;
  logic [ACC_W-1:0] r_acc_r;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [LD_W-1:0]  r_avg_l;
  logic [LD_W-1:0]  r_avg_r;
  logic             r_avg_vld;
  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_tmr;

  logic [ACC_W-1:0] w_acc_l_nxt;
  logic [ACC_W-1:0] w_acc_r_nxt;
  logic             w_last_smp;
  logic [LD_W:0]    w_sum;
  logic [LD_W-1:0]  w_diff;
  logic             w_sum_lt;
  logic             w_sum_gt;
  logic             w_unbal;
  logic             w_stepoff;
  logic             w_tmr_full;
  logic             w_tmr_clr;
  logic [1:0]       w_nxt_state;

  assign w_acc_l_nxt = r_acc_l + ACC_W'(i_lft_ld);
  assign w_acc_r_nxt = r_acc_r + ACC_W'(i_rght_ld);
  assign w_last_smp  = (AVG_LOG2 == 0) ? 1'b1 : (r_smp_cnt == CNT_W'(NSMP - 1));

  // Accumulate valid samples; on the block's last sample publish the truncated average.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_smp_cnt <= '0;
      r_avg_l   <= '0;
      r_avg_r   <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= 1'b0;
      if (i_ld_vld) begin
        if (w_last_smp) begin
          r_avg_l   <= LD_W'(w_acc_l_nxt >> AVG_LOG2);
          r_avg_r   <= LD_W'(w_acc_r_nxt >> AVG_LOG2);
          r_acc_l   <= '0;
          r_acc_r   <= '0;
          r_smp_cnt <= '0;
          r_avg_vld <= 1'b1;
        end else begin
          r_acc_l   <= w_acc_l_nxt;
          r_acc_r   <= w_acc_r_nxt;
          r_smp_cnt <= r_smp_cnt + 1'b1;
        end
      end
    end
  end

  // Weight and balance flags from the averaged samples (exact absolute difference).
  always_comb begin
    w_sum     = {1'b0, r_avg_l} + {1'b0, r_avg_r};
    w_diff    = (r_avg_l >= r_avg_r) ? (r_avg_l - r_avg_r) : (r_avg_r - r_avg_l);
    w_sum_lt  = (w_sum < SUM_LO);
    w_sum_gt  = (w_sum > SUM_HI);
    w_unbal   = ({1'b0, w_diff} > (w_sum >> BAL_SHIFT));
    w_stepoff = ({1'b0, w_diff} > (w_sum - (w_sum >> OFF_SHIFT)));
  end

  assign w_tmr_full = &r_tmr;

  // Next-state decision; weight/balance flags only count on a fresh average.
  always_comb begin
    w_nxt_state = r_state;
    w_tmr_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_avg_vld && w_sum_gt) w_nxt_state = WAIT;
      end
      WAIT: begin
        if (r_avg_vld && w_sum_lt)      w_nxt_state = IDLE;
        else if (r_avg_vld && w_unbal)  w_tmr_clr   = 1'b1;
        else if (w_tmr_full)            w_nxt_state = STEER;
      end
      STEER: begin
        if (r_avg_vld && w_sum_lt)        w_nxt_state = IDLE;
        else if (r_avg_vld && w_stepoff)  w_nxt_state = WAIT;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nxt_state;
  end

  // Balance timer: runs only while staying in WAIT, restarts on entry or imbalance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmr <= '0;
    end else if ((r_state != WAIT) || (w_nxt_state != WAIT) || w_tmr_clr) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  assign o_rider_off = (r_state == IDLE);
  assign o_en_steer  = (r_state == STEER);
  assign o_avg_vld   = r_avg_vld;

endmodule

// File: tb/tb_steer_en_gen.sv
// Directed bench for steer_en_gen with a short balance timer.
module tb_steer_en_gen;

  logic        clk;
  logic        rst;
  logic        ldVld;
  logic [11:0] lftLd;
  logic [11:0] rghtLd;
  logic        enSteer;
  logic        riderOff;
  logic        avgVld;

  int compareCount;
  int mismatchCount;
  int pulseCount;

  steer_en_gen #(
    .LD_W(12),
    .MIN_RIDER_WT('h200),
    .WT_HYST('h40),
    .BAL_SHIFT(2),
    .OFF_SHIFT(4),
    .AVG_LOG2(2),
    .TMR_W(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ld_vld(ldVld),
    .i_lft_ld(lftLd),
    .i_rght_ld(rghtLd),
    .o_en_steer(enSteer),
    .o_rider_off(riderOff),
    .o_avg_vld(avgVld)
  );

  // 50 MHz clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // One comparison: counts it, and flags a failure with observed/expected values.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive n back-to-back valid samples, then drop ld_vld; returns at the negedge after the last capture.
  task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ldVld  = 1'b1;
      lftLd  = l;
      rghtLd = r;
    end
    @(negedge clk);
    ldVld = 1'b0;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst    = 1'b1;
    ldVld  = 1'b0;
    lftLd  = '0;
    rghtLd = '0;
    #35;
    rst = 1'b0;

    // Reset state and a quiet 100-clock stretch.
    @(negedge clk);
    checkOutput("rst_rider_off", {15'd0, riderOff}, 16'd1);
    checkOutput("rst_en_steer", {15'd0, enSteer}, 16'd0);
    checkOutput("rst_avg_vld", {15'd0, avgVld}, 16'd0);
    pulseCount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (avgVld) pulseCount++;
    end
    checkOutput("quiet_avg_pulses", 16'(pulseCount), 16'd0);
    checkOutput("quiet_rider_off", {15'd0, riderOff}, 16'd1);

    // Sum exactly at MIN+HYST (0x240): no transition out of IDLE.
    applyStimulus(12'h120, 12'h120, 4);
    checkOutput("hi_edge_avg_vld", {15'd0, avgVld}, 16'd1);
    @(negedge clk);
    checkOutput("hi_edge_rider_off", {15'd0, riderOff}, 16'd1);

    // Balanced rider, sum 0x280: WAIT, then STEER after the timer expires.
    applyStimulus(12'h140, 12'h140, 4);
    checkOutput("mount_avg_vld", {15'd0, avgVld}, 16'd1);
    @(negedge clk);
    checkOutput("wait_rider_off", {15'd0, riderOff}, 16'd0);
    checkOutput("wait_en_steer", {15'd0, enSteer}, 16'd0);
    repeat (13) @(negedge clk);
    checkOutput("wait_early_en", {15'd0, enSteer}, 16'd0);
    repeat (3) @(negedge clk);
    checkOutput("steer_en", {15'd0, enSteer}, 16'd1);
    checkOutput("steer_rider_off", {15'd0, riderOff}, 16'd0);

    // Stepping off from STEER: diff 0x3E8 exceeds 15/16 of sum 0x3F8.
    applyStimulus(12'h3F0, 12'h008, 4);
    @(negedge clk);
    checkOutput("stepoff_en", {15'd0, enSteer}, 16'd0);
    checkOutput("stepoff_rider_off", {15'd0, riderOff}, 16'd0);

    // Unbalanced averages in WAIT keep restarting the timer.
    applyStimulus(12'h200, 12'h080, 24);
    @(negedge clk);
    checkOutput("unbal_hold_en", {15'd0, enSteer}, 16'd0);
    checkOutput("unbal_hold_rider_off", {15'd0, riderOff}, 16'd0);
    repeat (12) @(negedge clk);
    checkOutput("unbal_resume_early", {15'd0, enSteer}, 16'd0);
    repeat (5) @(negedge clk);
    checkOutput("unbal_resume_steer", {15'd0, enSteer}, 16'd1);

    // Sum exactly at MIN-HYST (0x1C0) stays in STEER; 0x1A0 drops to IDLE.
    applyStimulus(12'h0E0, 12'h0E0, 4);
    @(negedge clk);
    checkOutput("lo_edge_en", {15'd0, enSteer}, 16'd1);
    applyStimulus(12'h0D0, 12'h0D0, 4);
    @(negedge clk);
    checkOutput("off_rider_off", {15'd0, riderOff}, 16'd1);
    checkOutput("off_en", {15'd0, enSteer}, 16'd0);

    // Reset mid-average while in WAIT discards the partial block.
    applyStimulus(12'h140, 12'h140, 4);
    @(negedge clk);
    checkOutput("pre_rst_rider_off", {15'd0, riderOff}, 16'd0);
    @(negedge clk);
    ldVld  = 1'b1;
    lftLd  = 12'h100;
    rghtLd = 12'h100;
    @(negedge clk);
    @(negedge clk);
    ldVld = 1'b0;
    rst   = 1'b1;
    #1;
    checkOutput("async_rst_rider_off", {15'd0, riderOff}, 16'd1);
    checkOutput("async_rst_en", {15'd0, enSteer}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(12'h110, 12'h110, 4);
    checkOutput("fresh_avg_vld", {15'd0, avgVld}, 16'd1);
    @(negedge clk);
    checkOutput("fresh_avg_idle", {15'd0, riderOff}, 16'd1);
    applyStimulus(12'h140, 12'h140, 4);
    @(negedge clk);
    checkOutput("remount_rider_off", {15'd0, riderOff}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
